// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the single-line instruction fetch buffer.
package fetch_pkg;

    localparam int LINE_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } fetch_state_t;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/fetch_line_store.sv
// One cache line of ROM bytes: synchronous write by index, asynchronous read by index.
module fetch_line_store
    import fetch_pkg::*;
#(
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int OFF_W      = off_w(LINE_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [OFF_W-1:0] widx,
    input  logic [7:0]       wdata,
    input  logic [OFF_W-1:0] ridx,
    output logic [7:0]       rdata
);

    logic [7:0] mem [LINE_BYTES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/fetch_buffer.sv
// Single-line fetch buffer between the CPU ROM port and the SPI flash burst master.
//   state | meaning
//   IDLE  | serving hits; a miss latches the tag and moves to REQ
//   REQ   | holding mem_req/mem_addr until the master acks
//   FILL  | writing one byte per mem_valid until the line is full
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        romo,
    input  logic [15:0] pc,
    input  logic        flush,
    output logic [7:0]  rom,
    output logic        ready,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data
);

    localparam int OFF_W = off_w(LINE_BYTES);
    localparam logic [OFF_W:0] LAST_IDX = (OFF_W+1)'(LINE_BYTES - 1);

    fetch_state_t        state_q, state_d;
    logic [15-OFF_W:0]   tag_q;
    logic                valid_q;
    logic [OFF_W:0]      cnt_q;
    logic                flush_pend_q;

    logic       hit;
    logic       start_miss;
    logic       line_we;
    logic       fill_done;
    logic [7:0] line_rdata;

    assign hit = valid_q && (state_q == IDLE) && (tag_q == pc[15:OFF_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        line_we    = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (romo && !hit) begin
                    state_d    = REQ;
                    start_miss = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_valid) begin
                    line_we = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush arriving on the final byte's cycle must also leave the line invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q        <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (state_q == IDLE && flush) begin
                valid_q <= 1'b0;
            end
            if (state_q != IDLE && flush) begin
                flush_pend_q <= 1'b1;
            end
            if (start_miss) begin
                tag_q   <= pc[15:OFF_W];
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end
            if (line_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fill_done) begin
                valid_q      <= !(flush_pend_q || flush);
                flush_pend_q <= 1'b0;
            end
        end
    end

    fetch_line_store #(
        .LINE_BYTES (LINE_BYTES),
        .OFF_W      (OFF_W)
    ) u_line (
        .clk   (clk),
        .rst   (rst),
        .we    (line_we),
        .widx  (cnt_q[OFF_W-1:0]),
        .wdata (mem_data),
        .ridx  (pc[OFF_W-1:0]),
        .rdata (line_rdata)
    );

    assign mem_req  = (state_q == REQ);
    assign mem_addr = {tag_q, {OFF_W{1'b0}}};
    assign ready    = !romo || hit;
    assign rom      = (romo && hit) ? line_rdata : 8'h00;

endmodule
